// File: rtl/prbs_arbiter.sv
// Round-robin arbiter granting bursts of 4-bit PRBS beats; grant/valid are registered one edge after arbitration, a dropped request ends the burst on the following cycle.
// Optional PRBS_ARBITER_LOCKUP_GUARD_EN: a zero seed is replaced by 4'hF so the generator can never lock up.
module prbs_arbiter #(
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                    clk,
    input  logic                    RSTn,
    input  logic [NREQ-1:0]         req,
    input  logic                    seed_load,
    input  logic [3:0]              seed_val,
    output logic [NREQ-1:0]         gnt,
    output logic                    rnd_valid,
    output logic [3:0]              rnd_data,
    output logic [$clog2(NREQ)-1:0] rnd_id,
    output logic                    busy
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      gen_q, gen_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rnd_valid_q, rnd_valid_d;
    logic [IDW-1:0]  rnd_id_q, rnd_id_d;
    logic            busy_q, busy_d;

    logic [3:0]      seed_eff;
    logic            pick_found;
    logic [IDW-1:0]  pick;
    logic            last_beat;

    always_comb begin
`ifdef PRBS_ARBITER_LOCKUP_GUARD_EN
        seed_eff = (seed_val == 4'h0) ? 4'hF : seed_val;
`else
        seed_eff = seed_val;
`endif
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick       = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!pick_found && req[j]) begin
                pick_found = 1'b1;
                pick       = IDW'(j);
            end
        end
    end

    assign last_beat = (cnt_q == 4'(BURST_LEN - 1));

    always_comb begin
        state_d     = state_q;
        gen_d       = gen_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        rnd_valid_d = rnd_valid_q;
        rnd_id_d    = rnd_id_q;
        busy_d      = busy_q;

        // Generator only steps on a cycle where a beat is actually delivered.
        if (rnd_valid_q) begin
            gen_d = {gen_q[2:0], gen_q[3] ^ gen_q[2]};
        end

        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    gen_d = seed_eff;
                end else if (pick_found) begin
                    state_d        = BURST;
                    cnt_d          = 4'd0;
                    gnt_d          = '0;
                    gnt_d[pick]    = 1'b1;
                    rnd_valid_d    = 1'b1;
                    rnd_id_d       = pick;
                    busy_d         = 1'b1;
                end
            end
            BURST: begin
                cnt_d = cnt_q + 4'd1;
                if (last_beat || !req[rnd_id_q]) begin
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                    gnt_d       = '0;
                    rnd_valid_d = 1'b0;
                    rnd_id_d    = '0;
                    busy_d      = 1'b0;
                    rr_ptr_d    = (int'(rnd_id_q) == NREQ - 1) ? '0 : rnd_id_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            gen_q       <= 4'hF;
            rr_ptr_q    <= '0;
            cnt_q       <= 4'd0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gen_q       <= gen_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_id_q    <= rnd_id_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = gen_q;
    assign rnd_id    = rnd_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_prbs_arbiter.sv
// Directed bench for prbs_arbiter with hand-computed PRBS sequences; outputs sampled on the falling edge.
module tb_prbs_arbiter;
    logic       clk;
    logic       RSTn;
    logic [3:0] req;
    logic       seed_load;
    logic [3:0] seed_val;
    logic [3:0] gnt;
    logic       rnd_valid;
    logic [3:0] rnd_data;
    logic [1:0] rnd_id;
    logic       busy;

    int checks;
    int failures;

    prbs_arbiter #(.NREQ(4), .BURST_LEN(4)) dut (
        .clk       (clk),
        .RSTn      (RSTn),
        .req       (req),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .rnd_id    (rnd_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ck(input string tag, input logic [3:0] g, input logic v,
                      input logic [3:0] d, input logic [1:0] id, input logic b);
        logic [11:0] obs;
        logic [11:0] exp;
        obs = {gnt, rnd_valid, rnd_data, rnd_id, busy};
        exp = {g, v, d, id, b};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed={gnt,vld,data,id,busy}=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    task automatic ck_idle(input string tag, input logic [3:0] d);
        ck(tag, 4'b0000, 1'b0, d, 2'd0, 1'b0);
    endtask

    // Four beats; data packed first-beat-in-MSBs.
    task automatic burst(input string tag, input logic [1:0] id, input logic [15:0] dat);
        logic [3:0] oh;
        logic [3:0] d;
        oh = 4'b0001 << id;
        for (int k = 0; k < 4; k++) begin
            tick();
            d = dat[15 - 4*k -: 4];
            ck(tag, oh, 1'b1, d, id, 1'b1);
        end
    endtask

    task automatic rst_pulse(input string tag);
        RSTn = 1'b0;
        #1;
        ck_idle(tag, 4'hF);
        tick();
    endtask

    initial begin
        logic guard;
`ifdef PRBS_ARBITER_LOCKUP_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        checks    = 0;
        failures  = 0;
        RSTn      = 1'b0;
        req       = 4'b0000;
        seed_load = 1'b0;
        seed_val  = 4'h0;
        tick();
        tick();
        ck_idle("reset_state", 4'hF);

        // Single requester: one idle cycle then F,E,C,8.
        req = 4'b0001;
        RSTn = 1'b1;
        ck_idle("single_idle", 4'hF);
        burst("single_burst", 2'd0, 16'hFEC8);
        tick();
        ck_idle("single_after", 4'h1);
        req = 4'b0000;

        // Two requesters alternate round-robin with one idle gap.
        rst_pulse("rr_reset");
        req = 4'b0101;
        RSTn = 1'b1;
        ck_idle("rr_idle0", 4'hF);
        burst("rr_burst0", 2'd0, 16'hFEC8);
        tick();
        ck_idle("rr_gap0", 4'h1);
        burst("rr_burst2", 2'd2, 16'h1249);
        tick();
        ck_idle("rr_gap1", 4'h3);
        burst("rr_burst0b", 2'd0, 16'h36DA);
        tick();
        ck_idle("rr_gap2", 4'h5);
        req = 4'b0000;

        // Request dropped during beat 2: abort cycle, generator resumes at C.
        rst_pulse("abort_reset");
        req = 4'b0001;
        RSTn = 1'b1;
        ck_idle("abort_idle", 4'hF);
        tick();
        ck("abort_beat1", 4'b0001, 1'b1, 4'hF, 2'd0, 1'b1);
        tick();
        ck("abort_beat2", 4'b0001, 1'b1, 4'hE, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        ck_idle("abort_cycle", 4'hC);
        tick();
        ck_idle("abort_hold", 4'hC);
        req = 4'b0001;
        burst("abort_resume", 2'd0, 16'hC812);
        tick();
        ck_idle("abort_after", 4'h4);
        req = 4'b0000;

        // Seed load defers arbitration; seed and non-winner ignored in burst.
        rst_pulse("seed_reset");
        req       = 4'b0010;
        seed_load = 1'b1;
        seed_val  = 4'h9;
        RSTn = 1'b1;
        ck_idle("seed_pre", 4'hF);
        tick();
        ck_idle("seed_loaded", 4'h9);
        seed_load = 1'b0;
        tick();
        ck("seed_beat1", 4'b0010, 1'b1, 4'h9, 2'd1, 1'b1);
        req       = 4'b0011;
        seed_load = 1'b1;
        seed_val  = 4'h5;
        tick();
        ck("seed_beat2", 4'b0010, 1'b1, 4'h3, 2'd1, 1'b1);
        seed_load = 1'b0;
        tick();
        ck("seed_beat3", 4'b0010, 1'b1, 4'h6, 2'd1, 1'b1);
        tick();
        ck("seed_beat4", 4'b0010, 1'b1, 4'hD, 2'd1, 1'b1);
        tick();
        ck_idle("seed_gap", 4'hA);
        burst("seed_next_id0", 2'd0, 16'hA5B7);
        tick();
        ck_idle("seed_after", 4'hF);
        req = 4'b0000;

        // Zero seed: replaced by F with the guard, stuck at 0 without it.
        rst_pulse("zero_reset");
        req       = 4'b0001;
        seed_load = 1'b1;
        seed_val  = 4'h0;
        RSTn = 1'b1;
        ck_idle("zero_pre", 4'hF);
        tick();
        ck_idle("zero_loaded", guard ? 4'hF : 4'h0);
        seed_load = 1'b0;
        burst("zero_burst", 2'd0, guard ? 16'hFEC8 : 16'h0000);
        tick();
        ck_idle("zero_after", guard ? 4'h1 : 4'h0);
        req = 4'b0000;

        // Reset during beat 2 clears outputs at once; restart from F.
        rst_pulse("mid_reset0");
        req = 4'b0001;
        RSTn = 1'b1;
        ck_idle("mid_idle", 4'hF);
        tick();
        ck("mid_beat1", 4'b0001, 1'b1, 4'hF, 2'd0, 1'b1);
        tick();
        ck("mid_beat2", 4'b0001, 1'b1, 4'hE, 2'd0, 1'b1);
        RSTn = 1'b0;
        #1;
        ck_idle("mid_async_clear", 4'hF);
        tick();
        RSTn = 1'b1;
        ck_idle("mid_release", 4'hF);
        tick();
        ck("mid_restart", 4'b0001, 1'b1, 4'hF, 2'd0, 1'b1);
        req = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
